// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with wrapping N-bit position count
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   enc_a   encoder phase A (asynchronous to clk)
//   enc_b   encoder phase B (asynchronous to clk)
//   clear   synchronous count clear, active-high, beats step/err
//   count   N-bit position, modulo 2^N
//   dir     direction of last valid step (1 = up)
//   step    one-cycle pulse per valid step
//   err     one-cycle pulse when both phases change in one sample
// Option: define QDEC_FILTER_EN for a 3-cycle per-phase glitch filter.
module quad_decoder #(
  parameter int N = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enc_a,
  input  logic         enc_b,
  input  logic         clear,
  output logic [N-1:0] count,
  output logic         dir,
  output logic         step,
  output logic         err
);
`ifdef QDEC_FILTER_EN
  localparam int W = SYNC_STAGES + 2;
`else
  localparam int W = SYNC_STAGES;
`endif
  localparam int CW = $clog2(W + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] ic;
  logic [SYNC_STAGES-1:0] sa, sb;
  logic [1:0] s, la, cur, nxt, prev, prev_n;
  logic [N-1:0] count_n;
  logic dir_n, step_n, err_n, up, dn, bad, run;
  assign s = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};
  // la is the value s will hold after the coming edge; INIT latches the
  // baseline from it so the first RUN cycle compares like with like.
  assign la = {sa[SYNC_STAGES-2], sb[SYNC_STAGES-2]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sa <= '0;
      sb <= '0;
    end else begin
      sa <= {sa[SYNC_STAGES-2:0], enc_a};
      sb <= {sb[SYNC_STAGES-2:0], enc_b};
    end
`ifdef QDEC_FILTER_EN
  logic [1:0] h1, h2, fq, eq, eqn;
  // A phase is accepted once the synchronized value has agreed for three
  // consecutive samples (s, h1, h2); otherwise the held value fq persists.
  assign eq = ~(s ^ h1) & ~(h1 ^ h2);
  assign cur = (eq & s) | (~eq & fq);
  assign eqn = ~(la ^ s) & ~(s ^ h1);
  assign nxt = (eqn & la) | (~eqn & cur);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      h1 <= '0;
      h2 <= '0;
      fq <= '0;
    end else begin
      h1 <= s;
      h2 <= h1;
      fq <= cur;
    end
`else
  assign cur = s;
  assign nxt = la;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      ic    <= '0;
    end else begin
      state <= state_n;
      ic    <= (state == INIT) ? ic + CW'(1) : '0;
    end
  always_comb state_n = (state == INIT && ic == CW'(W - 1)) ? RUN : state;
  always_comb begin
    run     = (state == RUN);
    up      = (cur == {prev[0], ~prev[1]});
    dn      = (cur == {~prev[0], prev[1]});
    bad     = (cur == ~prev);
    prev_n  = run ? cur : nxt;
    count_n = clear ? '0 : (run && up) ? count + N'(1) : (run && dn) ? count - N'(1) : count;
    dir_n   = (clear || !run) ? dir : up ? 1'b1 : dn ? 1'b0 : dir;
    step_n  = run && !clear && (up || dn);
    err_n   = run && !clear && bad;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev  <= '0;
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      prev  <= prev_n;
      count <= count_n;
      dir   <= dir_n;
      step  <= step_n;
      err   <= err_n;
    end
endmodule
